// File: rtl/scoreboard_mc.sv
// Multi-commit in-order issue scoreboard: allocate at tail, out-of-order write-back, in-order retire.
// Optional SB_WB_BYPASS_EN: same-cycle write-backs visible on commit and forwarding outputs.
module scoreboard_mc #(
    parameter int Depth         = 8,
    parameter int DataWidth     = 32,
    parameter int PayloadWidth  = 64,
    parameter int NrWbPorts     = 4,
    parameter int NrCommitPorts = 2,
    parameter int IdxW          = $clog2(Depth)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PayloadWidth-1:0]               in_payload,
    output logic [IdxW-1:0]                       in_idx,
    input  logic [NrWbPorts-1:0]                  wb_valid,
    input  logic [NrWbPorts*IdxW-1:0]             wb_idx,
    input  logic [NrWbPorts*DataWidth-1:0]        wb_data,
    output logic [NrCommitPorts-1:0]              commit_valid,
    output logic [NrCommitPorts*PayloadWidth-1:0] commit_payload,
    output logic [NrCommitPorts*DataWidth-1:0]    commit_data,
    input  logic [NrCommitPorts-1:0]              commit_ack,
    output logic [Depth-1:0]                      fwd_issued,
    output logic [Depth-1:0]                      fwd_done,
    output logic [Depth*DataWidth-1:0]            fwd_data,
    output logic [IdxW:0]                         count,
    output logic                                  full,
    output logic                                  empty
);

    logic [Depth-1:0]        issued_q, issued_d;
    logic [Depth-1:0]        done_q, done_d;
    logic [PayloadWidth-1:0] payload_q [Depth];
    logic [PayloadWidth-1:0] payload_d [Depth];
    logic [DataWidth-1:0]    data_q [Depth];
    logic [DataWidth-1:0]    data_d [Depth];
    logic [IdxW-1:0]         head_q, head_d;
    logic [IdxW-1:0]         tail_q, tail_d;
    logic [IdxW:0]           count_q, count_d;

    logic [Depth-1:0]         wb_hit;
    logic [DataWidth-1:0]     wb_val [Depth];
    logic [Depth-1:0]         eff_done;
    logic [DataWidth-1:0]     eff_data [Depth];
    logic [NrCommitPorts-1:0] cv;
    logic [NrCommitPorts-1:0] ret;
    logic [IdxW-1:0]          cidx [NrCommitPorts];
    logic [IdxW:0]            nret;
    logic                     do_issue;

    assign count    = count_q;
    assign full     = (count_q == (IdxW+1)'(Depth));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !flush;
    assign in_idx   = tail_q;
    assign do_issue = in_valid && in_ready;

    assign commit_valid = cv;
    assign fwd_issued   = issued_q;
    assign fwd_done     = eff_done;

    // Ports are scanned low to high so the highest-numbered port wins.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < Depth; i++) begin
            wb_val[i] = data_q[i];
            for (int p = 0; p < NrWbPorts; p++) begin
                if (wb_valid[p] && wb_idx[p*IdxW +: IdxW] == IdxW'(i)) begin
                    wb_hit[i] = issued_q[i];
                    wb_val[i] = wb_data[p*DataWidth +: DataWidth];
                end
            end
        end
    end

    always_comb begin
`ifdef SB_WB_BYPASS_EN
        eff_done = done_q | wb_hit;
        for (int i = 0; i < Depth; i++) begin
            eff_data[i] = wb_hit[i] ? wb_val[i] : data_q[i];
        end
`else
        eff_done = done_q;
        for (int i = 0; i < Depth; i++) begin
            eff_data[i] = data_q[i];
        end
`endif
        fwd_data = '0;
        for (int i = 0; i < Depth; i++) begin
            fwd_data[i*DataWidth +: DataWidth] = eff_data[i];
        end
    end

    // Retirement is a contiguous prefix starting at head.
    always_comb begin
        logic vprev;
        logic rprev;
        vprev          = 1'b1;
        rprev          = 1'b1;
        cv             = '0;
        ret            = '0;
        nret           = '0;
        commit_payload = '0;
        commit_data    = '0;
        for (int k = 0; k < NrCommitPorts; k++) begin
            cidx[k] = head_q + IdxW'(k);
            cv[k]   = vprev && issued_q[cidx[k]] && eff_done[cidx[k]];
            vprev   = cv[k];
            ret[k]  = rprev && cv[k] && commit_ack[k];
            rprev   = ret[k];
            if (ret[k]) begin
                nret = nret + (IdxW+1)'(1);
            end
            commit_payload[k*PayloadWidth +: PayloadWidth] = payload_q[cidx[k]];
            commit_data[k*DataWidth +: DataWidth]          = eff_data[cidx[k]];
        end
    end

    always_comb begin
        issued_d  = issued_q;
        done_d    = done_q;
        payload_d = payload_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            issued_d = '0;
            done_d   = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            if (do_issue) begin
                issued_d[tail_q]  = 1'b1;
                done_d[tail_q]    = 1'b0;
                payload_d[tail_q] = in_payload;
                tail_d            = tail_q + IdxW'(1);
            end
            for (int i = 0; i < Depth; i++) begin
                if (wb_hit[i]) begin
                    done_d[i] = 1'b1;
                    data_d[i] = wb_val[i];
                end
            end
            // Retire after write-back so a retiring entry always ends cleared.
            for (int k = 0; k < NrCommitPorts; k++) begin
                if (ret[k]) begin
                    issued_d[cidx[k]] = 1'b0;
                    done_d[cidx[k]]   = 1'b0;
                end
            end
            head_d  = head_q + nret[IdxW-1:0];
            count_d = count_q + (IdxW+1)'(do_issue) - nret;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_q <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            issued_q <= issued_d;
            done_q   <= done_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        payload_q <= payload_d;
        data_q    <= data_d;
    end

endmodule

// File: tb/tb_scoreboard_mc.sv
// Randomised scoreboard bench for scoreboard_mc against a queue-of-records reference model.
module tb_scoreboard_mc;
    localparam int D  = 8;
    localparam int DW = 32;
    localparam int PW = 64;
    localparam int NW = 4;
    localparam int NC = 2;
    localparam int IW = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     in_payload = '0;
    logic [IW-1:0]     in_idx;
    logic [NW-1:0]     wb_valid = '0;
    logic [NW*IW-1:0]  wb_idx = '0;
    logic [NW*DW-1:0]  wb_data = '0;
    logic [NC-1:0]     commit_valid;
    logic [NC*PW-1:0]  commit_payload;
    logic [NC*DW-1:0]  commit_data;
    logic [NC-1:0]     commit_ack = '0;
    logic [D-1:0]      fwd_issued;
    logic [D-1:0]      fwd_done;
    logic [D*DW-1:0]   fwd_data;
    logic [IW:0]       count;
    logic              full;
    logic              empty;

    scoreboard_mc dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_idx(in_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_payload(commit_payload),
        .commit_data(commit_data), .commit_ack(commit_ack),
        .fwd_issued(fwd_issued), .fwd_done(fwd_done), .fwd_data(fwd_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] idx;
        logic [PW-1:0] payload;
        logic          done;
        logic [DW-1:0] data;
    } rec_t;

    rec_t             live[$];
    int               tail = 0;
    logic [PW+DW-1:0] exp_q[$];
    int               total = 0;
    int               bad = 0;

    logic [NC-1:0] exp_cv;
    logic [IW:0]   exp_count;
    logic          exp_full, exp_empty, exp_ready;
    logic [IW-1:0] exp_idx;
    logic [D-1:0]  exp_fi, exp_fd;
    logic [DW-1:0] exp_fdata [D];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic fl);
        rec_t r;
        logic prev;
        prev      = 1'b1;
        exp_count = (IW+1)'(live.size());
        exp_full  = (live.size() == D);
        exp_empty = (live.size() == 0);
        exp_ready = !exp_full && !fl;
        exp_idx   = IW'(tail);
        exp_cv    = '0;
        for (int k = 0; k < NC; k++) begin
            if (prev && k < live.size()) begin
                r = live[k];
                if (r.done) exp_cv[k] = 1'b1;
                else prev = 1'b0;
            end else begin
                prev = 1'b0;
            end
        end
        exp_fi = '0;
        exp_fd = '0;
        for (int j = 0; j < live.size(); j++) begin
            r = live[j];
            exp_fi[r.idx] = 1'b1;
            if (r.done) begin
                exp_fd[r.idx]    = 1'b1;
                exp_fdata[r.idx] = r.data;
            end
        end
    endtask

    // Next-cycle model: retire from queue front, then write-backs, then allocate.
    task automatic model_cycle(input logic iv, input logic [PW-1:0] pl,
                               input logic [NW-1:0] wv, input logic [NW*IW-1:0] wi,
                               input logic [NW*DW-1:0] wd, input logic [NC-1:0] ack,
                               input logic fl);
        rec_t r;
        int   n;
        logic prev;
        logic can_issue;
        if (fl) begin
            live.delete();
            tail = 0;
            return;
        end
        can_issue = (live.size() < D);
        n = 0;
        prev = 1'b1;
        for (int k = 0; k < NC; k++) begin
            if (prev && k < live.size()) begin
                r = live[k];
                if (r.done && ack[k]) n++;
                else prev = 1'b0;
            end else begin
                prev = 1'b0;
            end
        end
        repeat (n) begin
            r = live.pop_front();
            exp_q.push_back({r.payload, r.data});
        end
        for (int p = 0; p < NW; p++) begin
            if (wv[p]) begin
                for (int j = 0; j < live.size(); j++) begin
                    r = live[j];
                    if (r.idx == wi[p*IW +: IW]) begin
                        r.done  = 1'b1;
                        r.data  = wd[p*DW +: DW];
                        live[j] = r;
                    end
                end
            end
        end
        if (iv && can_issue) begin
            r.idx     = IW'(tail);
            r.payload = pl;
            r.done    = 1'b0;
            r.data    = '0;
            live.push_back(r);
            tail = (tail + 1) % D;
        end
    endtask

    task automatic step(input logic iv, input logic [PW-1:0] pl,
                        input logic [NW-1:0] wv, input logic [NW*IW-1:0] wi,
                        input logic [NW*DW-1:0] wd, input logic [NC-1:0] ack,
                        input logic fl);
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_exp(fl);
        in_valid   = iv;
        in_payload = pl;
        wb_valid   = wv;
        wb_idx     = wi;
        wb_data    = wd;
        commit_ack = ack;
        flush      = fl;
        model_cycle(iv, pl, wv, wi, wd, ack, fl);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic issue(input logic [PW-1:0] pl);
        step(1'b1, pl, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wb1(input logic [IW-1:0] idx, input logic [DW-1:0] d);
        step(1'b0, '0, 4'b0001, {9'd0, idx}, {96'd0, d}, '0, 1'b0);
    endtask

    task automatic ack_only(input logic [NC-1:0] a);
        step(1'b0, '0, '0, '0, '0, a, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        in_valid   = 1'b0;
        wb_valid   = '0;
        commit_ack = '0;
        flush      = 1'b0;
        live.delete();
        tail = 0;
        set_exp(1'b0);
    endtask

    always @(negedge clock) begin : monitor
        logic [PW+DW-1:0] e;
        logic prev;
        check("commit_valid", commit_valid, exp_cv);
        check("count", count, exp_count);
        check("full", full, exp_full);
        check("empty", empty, exp_empty);
        check("in_ready", in_ready, exp_ready);
        check("in_idx", in_idx, exp_idx);
        check("fwd_issued", fwd_issued, exp_fi);
        check("fwd_done", fwd_done, exp_fd);
        for (int i = 0; i < D; i++) begin
            if (exp_fd[i]) check("fwd_data", fwd_data[i*DW +: DW], exp_fdata[i]);
        end
        if (!reset && !flush) begin
            prev = 1'b1;
            for (int k = 0; k < NC; k++) begin
                if (prev && commit_valid[k] && commit_ack[k]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_payload", commit_payload[k*PW +: PW], e[PW+DW-1:DW]);
                        check("commit_data", commit_data[k*DW +: DW], e[DW-1:0]);
                    end
                end else begin
                    prev = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [NW-1:0]    wv;
        logic [NW*IW-1:0] wi;
        logic [NW*DW-1:0] wd;
        rec_t r;
        set_exp(1'b0);

        // reset with three live entries
        for (int i = 0; i < 3; i++) issue(64'h100 + 64'(i));
        do_reset();
        idle();

        // fill to full, hold the ninth offer, retire one, then wrap
        for (int i = 0; i < 8; i++) issue(64'h200 + 64'(i));
        issue(64'h2ff);
        wb1(3'd0, 32'ha0);
        step(1'b1, 64'h2fe, '0, '0, '0, 2'b01, 1'b0);
        issue(64'h2fd);
        idle();
        do_flush();

        // out-of-order completion, pair retire
        issue(64'hA);
        issue(64'hB);
        issue(64'hC);
        wb1(3'd2, 32'hc0);
        wb1(3'd1, 32'hb0);
        wb1(3'd0, 32'ha0);
        idle();
        ack_only(2'b11);
        idle();
        do_flush();

        // gap at head: ack on port 1 only is ignored
        issue(64'h300);
        issue(64'h301);
        wb1(3'd1, 32'h31);
        ack_only(2'b10);
        ack_only(2'b10);
        do_flush();

        // two ports hit idx 2 in one cycle
        for (int i = 0; i < 3; i++) issue(64'h400 + 64'(i));
        step(1'b0, '0, 4'b1001, {3'd2, 3'd0, 3'd0, 3'd2},
             {32'h33, 32'h0, 32'h0, 32'h11}, '0, 1'b0);
        idle();
        @(negedge clock);
        #1;
        check("wb_port_priority", fwd_data[2*DW +: DW], 32'h33);
        do_flush();

        // flush beats a same-cycle write-back and ack; stale wb dropped
        for (int i = 0; i < 5; i++) issue(64'h500 + 64'(i));
        wb1(3'd0, 32'h50);
        step(1'b0, '0, 4'b0001, {9'd0, 3'd2}, {96'd0, 32'h52}, 2'b01, 1'b1);
        wb1(3'd3, 32'h53);
        idle();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                continue;
            end
            wv = '0;
            wi = '0;
            wd = '0;
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    wv[p] = 1'b1;
                    wd[p*DW +: DW] = $urandom;
                    if (live.size() > 0 && $urandom_range(0, 9) < 7) begin
                        r = live[$urandom_range(0, live.size() - 1)];
                        wi[p*IW +: IW] = r.idx;
                    end else begin
                        wi[p*IW +: IW] = IW'($urandom_range(0, D - 1));
                    end
                end
            end
            step($urandom_range(0, 9) < 7, {$urandom, $urandom}, wv, wi, wd,
                 NC'($urandom_range(0, 3)), $urandom_range(0, 99) == 0);
        end
        idle();
        idle();
        @(negedge clock);
        #1;
        check("leftover_retires", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
